// File: rtl/spi_minion_adapter_mc.sv
// SPI minion adapter: per-channel core<->SPI FIFOs with round-robin SPI reads.
// Optional sticky per-channel overflow flags: define SPI_MINION_ADAPTER_MC_OVERFLOW_EN.
module spi_minion_adapter_mc #(
    parameter int NBITS = 12,
    parameter int NCHAN = 4,
    parameter int DEPTH = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       pull_en,
    output logic                                       pull_msg_val,
    output logic                                       pull_msg_spc,
    output logic [NBITS-3:0]                           pull_msg_data,
    input  logic                                       push_en,
    input  logic                                       push_msg_val_wrt,
    input  logic                                       push_msg_val_rd,
    input  logic [NBITS-3:0]                           push_msg_data,
    input  logic [NCHAN*(NBITS-2-$clog2(NCHAN))-1:0]   recv_msg,
    input  logic [NCHAN-1:0]                           recv_val,
    output logic [NCHAN-1:0]                           recv_rdy,
    output logic [NCHAN*(NBITS-2-$clog2(NCHAN))-1:0]   send_msg,
    output logic [NCHAN-1:0]                           send_val,
    input  logic [NCHAN-1:0]                           send_rdy
`ifdef SPI_MINION_ADAPTER_MC_OVERFLOW_EN
    ,
    output logic [NCHAN-1:0]                           overflow
`endif
);

    localparam int CB = $clog2(NCHAN);
    localparam int PW = NBITS - 2 - CB;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0]    cm_mem_r [NCHAN][DEPTH];
    logic [PW-1:0]    mc_mem_r [NCHAN][DEPTH];
    logic [AW-1:0]    cm_wp_r  [NCHAN];
    logic [AW-1:0]    cm_rp_r  [NCHAN];
    logic [AW-1:0]    mc_wp_r  [NCHAN];
    logic [AW-1:0]    mc_rp_r  [NCHAN];
    logic [CW-1:0]    cm_cnt_r [NCHAN];
    logic [CW-1:0]    mc_cnt_r [NCHAN];
    logic [CB-1:0]    rr_r;

    logic [NCHAN-1:0] cm_full_s, cm_empty_s, mc_full_s, mc_empty_s;
    logic [NCHAN-1:0] cm_enq_s, cm_deq_s, mc_enq_s, mc_deq_s;
    logic             wr_req_s, rd_req_s, rd_any_s, rd_gnt_s;
    logic [CB-1:0]    wr_chan_s, gnt_chan_s, cand_s;
    logic [PW-1:0]    wr_payload_s;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        logic [AW-1:0] n;
        if (p == AW'(DEPTH - 1)) begin
            n = {AW{1'b0}};
        end else begin
            n = p + AW'(1);
        end
        return n;
    endfunction

    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c, input logic enq, input logic deq);
        logic [CW-1:0] n;
        case ({enq, deq})
            2'b10:   n = c + CW'(1);
            2'b01:   n = c - CW'(1);
            default: n = c;
        endcase
        return n;
    endfunction

    assign wr_req_s     = push_en & push_msg_val_wrt;
    assign rd_req_s     = pull_en & push_msg_val_rd;
    assign wr_chan_s    = push_msg_data[NBITS-3:PW];
    assign wr_payload_s = push_msg_data[PW-1:0];

    // Occupancy status and per-queue enqueue/dequeue strobes
    always_comb begin
        cm_full_s  = {NCHAN{1'b0}};
        cm_empty_s = {NCHAN{1'b0}};
        mc_full_s  = {NCHAN{1'b0}};
        mc_empty_s = {NCHAN{1'b0}};
        cm_enq_s   = {NCHAN{1'b0}};
        cm_deq_s   = {NCHAN{1'b0}};
        mc_enq_s   = {NCHAN{1'b0}};
        mc_deq_s   = {NCHAN{1'b0}};
        for (int i = 0; i < NCHAN; i++) begin
            cm_full_s[i]  = (cm_cnt_r[i] == CW'(DEPTH));
            cm_empty_s[i] = (cm_cnt_r[i] == CW'(0));
            mc_full_s[i]  = (mc_cnt_r[i] == CW'(DEPTH));
            mc_empty_s[i] = (mc_cnt_r[i] == CW'(0));
            // ready is occupancy-only, so a full queue never accepts even when draining
            cm_enq_s[i]   = recv_val[i] & ~cm_full_s[i];
            cm_deq_s[i]   = rd_gnt_s & (gnt_chan_s == CB'(i));
            mc_enq_s[i]   = wr_req_s & (wr_chan_s == CB'(i)) & ~mc_full_s[i];
            mc_deq_s[i]   = send_rdy[i] & ~mc_empty_s[i];
        end
    end

    // Round-robin pick of the first non-empty CM queue at or after rr
    always_comb begin
        gnt_chan_s = {CB{1'b0}};
        rd_any_s   = 1'b0;
        cand_s     = {CB{1'b0}};
        for (int k = NCHAN - 1; k >= 0; k--) begin
            cand_s     = rr_r + CB'(k);
            gnt_chan_s = cm_empty_s[cand_s] ? gnt_chan_s : cand_s;
            rd_any_s   = rd_any_s | ~cm_empty_s[cand_s];
        end
        rd_gnt_s = rd_req_s & rd_any_s;
    end

    // SPI-facing and core-facing outputs, forced low while reset is held
    always_comb begin
        pull_msg_val  = reset & rd_gnt_s;
        pull_msg_data = {(NBITS-2){1'b0}};
        if (reset && rd_gnt_s) begin
            pull_msg_data = {gnt_chan_s, cm_mem_r[gnt_chan_s][cm_rp_r[gnt_chan_s]]};
        end else begin
            pull_msg_data = {(NBITS-2){1'b0}};
        end
        pull_msg_spc = reset & ~mc_full_s[wr_chan_s] &
                       (~wr_req_s | (mc_cnt_r[wr_chan_s] < CW'(DEPTH - 1)));
        for (int i = 0; i < NCHAN; i++) begin
            recv_rdy[i]           = reset & ~cm_full_s[i];
            send_val[i]           = reset & ~mc_empty_s[i];
            send_msg[i*PW +: PW]  = mc_mem_r[i][mc_rp_r[i]];
        end
    end

    // Queue storage, pointers and occupancy for both directions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCHAN; i++) begin
                cm_wp_r[i]  <= {AW{1'b0}};
                cm_rp_r[i]  <= {AW{1'b0}};
                mc_wp_r[i]  <= {AW{1'b0}};
                mc_rp_r[i]  <= {AW{1'b0}};
                cm_cnt_r[i] <= {CW{1'b0}};
                mc_cnt_r[i] <= {CW{1'b0}};
                for (int d = 0; d < DEPTH; d++) begin
                    cm_mem_r[i][d] <= {PW{1'b0}};
                    mc_mem_r[i][d] <= {PW{1'b0}};
                end
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (cm_enq_s[i]) begin
                    cm_mem_r[i][cm_wp_r[i]] <= recv_msg[i*PW +: PW];
                    cm_wp_r[i]              <= ptr_next(cm_wp_r[i]);
                end
                if (cm_deq_s[i]) begin
                    cm_rp_r[i] <= ptr_next(cm_rp_r[i]);
                end
                if (mc_enq_s[i]) begin
                    mc_mem_r[i][mc_wp_r[i]] <= wr_payload_s;
                    mc_wp_r[i]              <= ptr_next(mc_wp_r[i]);
                end
                if (mc_deq_s[i]) begin
                    mc_rp_r[i] <= ptr_next(mc_rp_r[i]);
                end
                cm_cnt_r[i] <= cnt_next(cm_cnt_r[i], cm_enq_s[i], cm_deq_s[i]);
                mc_cnt_r[i] <= cnt_next(mc_cnt_r[i], mc_enq_s[i], mc_deq_s[i]);
            end
        end
    end

    // Round-robin pointer advances past each granted channel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_r <= {CB{1'b0}};
        end else if (rd_gnt_s) begin
            rr_r <= gnt_chan_s + CB'(1);
        end else begin
            rr_r <= rr_r;
        end
    end

`ifdef SPI_MINION_ADAPTER_MC_OVERFLOW_EN
    logic [NCHAN-1:0] drop_s;
    logic [NCHAN-1:0] overflow_r;

    assign drop_s   = wr_req_s ? (mc_full_s & ({{(NCHAN-1){1'b0}}, 1'b1} << wr_chan_s)) : {NCHAN{1'b0}};
    assign overflow = overflow_r;

    // Sticky record of writes dropped on a full MC queue
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= {NCHAN{1'b0}};
        end else begin
            overflow_r <= overflow_r | drop_s;
        end
    end
`endif

endmodule

// File: tb/tb_spi_minion_adapter_mc.sv
// Directed self-checking bench for spi_minion_adapter_mc (NCHAN=4, DEPTH=2, NBITS=12).
module tb_spi_minion_adapter_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        pull_en, pull_msg_val, pull_msg_spc;
    logic [9:0]  pull_msg_data;
    logic        push_en, push_msg_val_wrt, push_msg_val_rd;
    logic [9:0]  push_msg_data;
    logic [31:0] recv_msg, send_msg;
    logic [3:0]  recv_val, recv_rdy, send_val, send_rdy;
`ifdef SPI_MINION_ADAPTER_MC_OVERFLOW_EN
    logic [3:0]  overflow;
`endif

    int passed = 0;
    int total  = 0;

    spi_minion_adapter_mc #(.NBITS(12), .NCHAN(4), .DEPTH(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .pull_en          (pull_en),
        .pull_msg_val     (pull_msg_val),
        .pull_msg_spc     (pull_msg_spc),
        .pull_msg_data    (pull_msg_data),
        .push_en          (push_en),
        .push_msg_val_wrt (push_msg_val_wrt),
        .push_msg_val_rd  (push_msg_val_rd),
        .push_msg_data    (push_msg_data),
        .recv_msg         (recv_msg),
        .recv_val         (recv_val),
        .recv_rdy         (recv_rdy),
        .send_msg         (send_msg),
        .send_val         (send_val),
        .send_rdy         (send_rdy)
`ifdef SPI_MINION_ADAPTER_MC_OVERFLOW_EN
        ,
        .overflow         (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rd(input logic on);
        pull_en         = on;
        push_msg_val_rd = on;
    endtask

    task automatic wr(input logic on, input logic [9:0] d);
        push_en          = on;
        push_msg_val_wrt = on;
        push_msg_data    = d;
    endtask

    initial begin
        reset = 1'b0;
        rd(1'b0);
        wr(1'b0, 10'h000);
        recv_msg = 32'h0;
        recv_val = 4'h0;
        send_rdy = 4'h0;
        #3;
        chk("rst_recv_rdy", 32'(recv_rdy), 32'h0);
        chk("rst_send_val", 32'(send_val), 32'h0);
        chk("rst_pull_val", 32'(pull_msg_val), 32'h0);
        chk("rst_pull_data", 32'(pull_msg_data), 32'h0);
        chk("rst_pull_spc", 32'(pull_msg_spc), 32'h0);
        #10 reset = 1'b1;
        tick();
        chk("post_rst_recv_rdy", 32'(recv_rdy), 32'hF);
        chk("post_rst_send_val", 32'(send_val), 32'h0);
        chk("post_rst_spc", 32'(pull_msg_spc), 32'h1);
`ifdef SPI_MINION_ADAPTER_MC_OVERFLOW_EN
        chk("post_rst_ovf", 32'(overflow), 32'h0);
`endif

        // single write to channel 2
        wr(1'b1, 10'h2A5);
        #1 chk("wr2_spc", 32'(pull_msg_spc), 32'h1);
        tick();
        wr(1'b0, 10'h000);
        #1 chk("wr2_send_val", 32'(send_val), 32'h4);
        chk("wr2_send_msg", 32'(send_msg[23:16]), 32'hA5);
        send_rdy = 4'b0100;
        tick();
        send_rdy = 4'h0;
        #1 chk("wr2_drained", 32'(send_val), 32'h0);

        // round-robin reads over channels 0,1,3
        recv_msg = 32'h3300_2211;
        recv_val = 4'b1011;
        tick();
        recv_val = 4'h0;
        rd(1'b1);
        #1 chk("rr_rd0_val", 32'(pull_msg_val), 32'h1);
        chk("rr_rd0_data", 32'(pull_msg_data), 32'h011);
        tick();
        chk("rr_rd1_data", 32'(pull_msg_data), 32'h122);
        tick();
        chk("rr_rd2_data", 32'(pull_msg_data), 32'h333);
        tick();
        chk("rr_rd3_val", 32'(pull_msg_val), 32'h0);
        chk("rr_rd3_data", 32'(pull_msg_data), 32'h0);
        rd(1'b0);

        // fill MC channel 1 and overflow it
        wr(1'b1, 10'h15A);
        #1 chk("ovf_w1_spc", 32'(pull_msg_spc), 32'h1);
        tick();
        wr(1'b1, 10'h16B);
        #1 chk("ovf_w2_spc", 32'(pull_msg_spc), 32'h0);
        tick();
        wr(1'b1, 10'h17C);
        #1 chk("ovf_w3_spc", 32'(pull_msg_spc), 32'h0);
        tick();
        wr(1'b0, 10'h000);
        #1 chk("ovf_send_val", 32'(send_val), 32'h2);
        chk("ovf_send_msg", 32'(send_msg[15:8]), 32'h5A);
`ifdef SPI_MINION_ADAPTER_MC_OVERFLOW_EN
        chk("ovf_flag", 32'(overflow), 32'h2);
`endif
        send_rdy = 4'b0010;
        tick();
        chk("ovf_second", 32'(send_msg[15:8]), 32'h6B);
        chk("ovf_second_val", 32'(send_val), 32'h2);
        tick();
        send_rdy = 4'h0;
        #1 chk("ovf_third_dropped", 32'(send_val), 32'h0);

        // full CM ch0: enqueue refused while a read drains it
        recv_val = 4'b0001;
        recv_msg = 32'h0000_0041;
        tick();
        recv_msg = 32'h0000_0042;
        tick();
        recv_msg = 32'h0000_0043;
        rd(1'b1);
        #1 chk("full_recv_rdy", 32'(recv_rdy), 32'hE);
        chk("full_rd_data", 32'(pull_msg_data), 32'h041);
        tick();
        recv_val = 4'h0;
        rd(1'b0);
        #1 chk("full_after_rdy", 32'(recv_rdy), 32'hF);
        rd(1'b1);
        #1 chk("full_rd2_data", 32'(pull_msg_data), 32'h042);
        tick();
        chk("full_rd3_val", 32'(pull_msg_val), 32'h0);
        rd(1'b0);

        // fill every queue to depth, then reset mid-cycle
        recv_msg = 32'hD3D2_D1D0;
        recv_val = 4'hF;
        tick();
        tick();
        recv_val = 4'h0;
        for (int c = 0; c < 4; c++) begin
            for (int n = 0; n < 2; n++) begin
                wr(1'b1, {c[1:0], 8'hE0 + 8'(2 * c + n)});
                tick();
            end
        end
        wr(1'b0, 10'h000);
        #1 chk("fill_send_val", 32'(send_val), 32'hF);
        chk("fill_recv_rdy", 32'(recv_rdy), 32'h0);
        chk("fill_send_msg", 32'(send_msg), 32'hE6E4_E2E0);
        rd(1'b1);
        #1 chk("fill_rd_data", 32'(pull_msg_data), 32'h1D1);
        tick();
        reset = 1'b0;
        #1 chk("mid_rst_recv_rdy", 32'(recv_rdy), 32'h0);
        chk("mid_rst_send_val", 32'(send_val), 32'h0);
        chk("mid_rst_pull_val", 32'(pull_msg_val), 32'h0);
        chk("mid_rst_pull_data", 32'(pull_msg_data), 32'h0);
        chk("mid_rst_spc", 32'(pull_msg_spc), 32'h0);
        rd(1'b0);
        #3 reset = 1'b1;
        tick();
        chk("rel_recv_rdy", 32'(recv_rdy), 32'hF);
        chk("rel_send_val", 32'(send_val), 32'h0);
`ifdef SPI_MINION_ADAPTER_MC_OVERFLOW_EN
        chk("rel_ovf", 32'(overflow), 32'h0);
`endif
        rd(1'b1);
        #1 chk("rel_rd_val", 32'(pull_msg_val), 32'h0);
        chk("rel_rd_data", 32'(pull_msg_data), 32'h0);
        rd(1'b0);
        // rr must restart at 0: with ch1 and ch3 pending, ch1 wins
        recv_msg = 32'h5500_6600;
        recv_val = 4'b1010;
        tick();
        recv_val = 4'h0;
        rd(1'b1);
        #1 chk("rel_rr_data", 32'(pull_msg_data), 32'h166);
        tick();
        chk("rel_rr_next", 32'(pull_msg_data), 32'h355);
        rd(1'b0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_minion_adapter_mc.md
SPI_MINION_ADAPTER_MC -- requirements
Module: spi_minion_adapter_mc

Interface
REQ-001 SHALL have parameter NBITS, default 12: SPI packet width; 2 flow-control bits plus a {chan, payload} field of NBITS-2 bits.
REQ-002 SHALL have parameter NCHAN, default 4, power of two >= 2: channel count; CB = clog2(NCHAN), PW = NBITS-2-CB payload bits.
REQ-003 SHALL have parameter DEPTH, default 2, >= 1: entries per queue, every queue.
REQ-004 SHALL have ports: clk  in  1  clock; one clock, all state on rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-low.
REQ-006 pull_en  in  1  SPI-side pull strobe; pull_msg_val  out  1  read data valid; pull_msg_spc  out  1  addressed channel has space; pull_msg_data  out  NBITS-2  {chan, payload}.
REQ-007 push_en  in  1  SPI-side push strobe; push_msg_val_wrt  in  1  write request; push_msg_val_rd  in  1  read request; push_msg_data  in  NBITS-2  {chan, payload}.
REQ-008 recv_msg  in  NCHAN*PW; recv_val  in  NCHAN; recv_rdy  out  NCHAN: per-channel core-to-minion (CM) inputs, channel i at slice i.
REQ-009 send_msg  out  NCHAN*PW; send_val  out  NCHAN; send_rdy  in  NCHAN: per-channel minion-to-core (MC) outputs.

Function
REQ-010 SHALL hold NCHAN CM queues and NCHAN MC queues, each DEPTH entries, normal (non-bypass) FIFO, 1-cycle enqueue-to-visible latency.
REQ-011 Queue recv_rdy SHALL depend only on current occupancy; full queue rejects enqueue even if a dequeue occurs the same cycle.
REQ-012 Write: push_en & push_msg_val_wrt SHALL enqueue payload into MC queue chan = push_msg_data[NBITS-3:PW].
REQ-013 Write to a full MC queue SHALL drop the payload; other queues unaffected.
REQ-014 pull_msg_spc SHALL be combinational for the channel addressed by push_msg_data: 1 iff that MC queue is not full and (no write this cycle or free entries > 1).
REQ-015 Read: pull_en & push_msg_val_rd SHALL dequeue one entry from the CM queue selected by round-robin among non-empty CM queues, starting at pointer rr.
REQ-016 On a read grant to channel g: pull_msg_val = 1, pull_msg_data = {g, payload}, rr <= (g+1) mod NCHAN, same cycle combinational data.
REQ-017 Read with all CM queues empty, or no read request: pull_msg_val = 0, pull_msg_data = 0, rr unchanged.
REQ-018 Read and write in the same cycle SHALL both proceed independently.
REQ-019 Core-side enqueue and SPI-side dequeue on the same queue in one cycle SHALL both proceed; occupancy unchanged.
REQ-020 Pointer wrap: each queue read/write index SHALL wrap DEPTH-1 -> 0; occupancy counter width clog2(DEPTH)+1.

Reset
REQ-021 reset low SHALL immediately (asynchronously) empty all queues, clear rr to 0 and clear overflow state.
REQ-022 While reset low: recv_rdy = 0, send_val = 0, pull_msg_val = 0, pull_msg_data = 0, pull_msg_spc = 0.
REQ-023 First edge after reset high: recv_rdy all 1, send_val all 0, pull_msg_spc = 1.
REQ-024 Reset asserted mid-transfer SHALL discard all queued data; no partial entry survives.

Configuration
REQ-025 Macro SPI_MINION_ADAPTER_MC_OVERFLOW_EN defined: output overflow  NCHAN  sticky bit per channel, set on the cycle after a dropped write (REQ-013), cleared only by reset.
REQ-026 Macro undefined: overflow port absent, drops silent; all other behaviour identical.

Verification (NCHAN=4, DEPTH=2, NBITS=12)
REQ-027 Write chan 2 payload 0xA5 -> next cycle send_val = 0b0100, send_msg slice 2 = 0xA5; pull_msg_spc = 1 during write.
REQ-028 Core enqueues 0x11 ch0, 0x22 ch1, 0x33 ch3; three reads -> pull_msg_data 0x011, 0x122, 0x333 in order; fourth read -> pull_msg_val = 0, data 0.
REQ-029 Two writes ch1 with send_rdy = 0: second write shows pull_msg_spc = 0; third write dropped, send_msg ch1 still 0x first payload; overflow = 0b0010 when macro defined.
REQ-030 Full CM queue ch0 with recv_val = 1 and simultaneous read -> recv_rdy[0] = 0 that cycle, entry count drops to 1.
REQ-031 Reset low mid-stream with 2 entries in each queue -> outputs per REQ-022 within same cycle; after release recv_rdy = 0b1111, rr = 0, read returns pull_msg_val = 0.
